// File: rtl/alu_issue_ctrl.sv
// Issue controller between decode and the 16-bit ALU: registers operands, waits an
// opcode-dependent latency, captures the result and Z/V/N flags, and hands the result downstream.
module alu_issue_ctrl #(
  parameter int ALU_LAT   = 1,
  parameter int RED_EXTRA = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  opcode,
  input  logic [15:0] rs_data,
  input  logic [15:0] rt_data,
  input  logic [15:0] rd_data,
  input  logic [15:0] imm,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_ovfl,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result_q,
  output logic        flag_Z,
  output logic        flag_V,
  output logic        flag_N,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_RED  = 4'h3;
  localparam logic [3:0] OP_SLL  = 4'h4;
  localparam logic [3:0] OP_SRA  = 4'h5;
  localparam logic [3:0] OP_ROR  = 4'h6;
  localparam logic [3:0] OP_PADD = 4'h7;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [3:0] LAT_BASE = 4'(ALU_LAT);
  localparam logic [3:0] LAT_LONG = 4'(ALU_LAT + RED_EXTRA);

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]         r_cnt_p0;
  logic [15:0]        r_alu_a_p0;
  logic [15:0]        r_alu_b_p0;
  logic [3:0]         r_alu_op_p0;
  logic signed [15:0] r_result_p1;
  logic               r_flag_z_p1;
  logic               r_flag_v_p1;
  logic               r_flag_n_p1;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_capture;
  logic signed [15:0] w_result_s;

  // LLB/LHB modify rd in place, so they read rd instead of rs.
  function automatic logic f_sel_rd(input logic [3:0] op);
    return (op == 4'hA) || (op == 4'hB);
  endfunction

  function automatic logic f_sel_imm(input logic [3:0] op);
    case (op)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] f_latency(input logic [3:0] op);
    return ((op == OP_RED) || (op == OP_PADD)) ? LAT_LONG : LAT_BASE;
  endfunction

  function automatic logic f_upd_zvn(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic f_upd_z_only(input logic [3:0] op);
    return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

  assign w_accept   = in_valid & w_in_ready;
  assign w_capture  = (r_state == S_EXEC) && (r_cnt_p0 == 4'd1);
  assign w_result_s = signed'(alu_result);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = (opcode == OP_HLT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (r_cnt_p0 == 4'd1) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_accept) begin
          w_state_nxt = (opcode == OP_HLT) ? S_HALT : S_EXEC;
        end else if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = 1'b0;
    out_valid  = 1'b0;
    halted     = 1'b0;
    case (r_state)
      S_IDLE: w_in_ready = 1'b1;
      S_HOLD: begin
        w_in_ready = out_ready;
        out_valid  = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // Stage p0: operand/opcode capture at accept; these stay frozen until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_p0    <= 4'd0;
      r_alu_a_p0  <= 16'h0000;
      r_alu_b_p0  <= 16'h0000;
      r_alu_op_p0 <= 4'h0;
    end else if (w_accept) begin
      r_cnt_p0    <= f_latency(opcode);
      r_alu_a_p0  <= f_sel_rd(opcode)  ? rd_data : rs_data;
      r_alu_b_p0  <= f_sel_imm(opcode) ? imm     : rt_data;
      r_alu_op_p0 <= opcode;
    end else if (r_state == S_EXEC) begin
      r_cnt_p0 <= r_cnt_p0 - 4'd1;
    end
  end

  // Stage p1: result and flag capture on the final EXEC edge; reset discards in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result_p1 <= '0;
      r_flag_z_p1 <= 1'b0;
      r_flag_v_p1 <= 1'b0;
      r_flag_n_p1 <= 1'b0;
    end else if (w_capture) begin
      r_result_p1 <= w_result_s;
      if (f_upd_zvn(r_alu_op_p0) || f_upd_z_only(r_alu_op_p0)) begin
        r_flag_z_p1 <= (w_result_s == 16'sd0);
      end
      if (f_upd_zvn(r_alu_op_p0)) begin
        r_flag_v_p1 <= alu_ovfl;
        r_flag_n_p1 <= (w_result_s < 16'sd0);
      end
    end
  end

  assign in_ready = w_in_ready;
  assign alu_A    = r_alu_a_p0;
  assign alu_B    = r_alu_b_p0;
  assign alu_op   = r_alu_op_p0;
  assign result_q = unsigned'(r_result_p1);
  assign flag_Z   = r_flag_z_p1;
  assign flag_V   = r_flag_v_p1;
  assign flag_N   = r_flag_n_p1;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with default parameters (ALU_LAT=1, RED_EXTRA=1);
// the ALU result/overflow inputs are driven directly with hand-chosen values.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] rs_data, rt_data, rd_data, imm;
  logic [15:0] alu_A, alu_B;
  logic [3:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result_q;
  logic        flag_Z, flag_V, flag_N;
  logic        halted;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs_data(rs_data), .rt_data(rt_data), .rd_data(rd_data), .imm(imm),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_result(alu_result), .alu_ovfl(alu_ovfl),
    .out_valid(out_valid), .out_ready(out_ready), .result_q(result_q),
    .flag_Z(flag_Z), .flag_V(flag_V), .flag_N(flag_N), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] zvn();
    return {13'd0, flag_Z, flag_V, flag_N};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [15:0] rs, input logic [15:0] rt,
                       input logic [15:0] rd, input logic [15:0] im,
                       input logic [15:0] res, input logic ovf);
    opcode = op; rs_data = rs; rt_data = rt; rd_data = rd; imm = im;
    alu_result = res; alu_ovfl = ovf;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (out_valid) break;
    end
    if (!out_valid) n = 99;
    chk(tag, 16'(n), 16'(exp_lat));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] held_res, held_a, held_b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = 4'h0;
    rs_data = '0; rt_data = '0; rd_data = '0; imm = '0; alu_result = '0; alu_ovfl = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_alu_A", alu_A, 16'h0000);
    chk("rst_alu_B", alu_B, 16'h0000);
    chk("rst_result", result_q, 16'h0000);
    chk("rst_flags", zvn(), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);

    // ADD with overflow
    issue(4'h0, 16'h7FFF, 16'h0001, 16'h5555, 16'h9999, 16'h7FFF, 1'b1);
    chk("add_alu_A", alu_A, 16'h7FFF);
    chk("add_alu_B", alu_B, 16'h0001);
    chk("add_exec_in_ready", 16'(in_ready), 16'd0);
    chk("add_exec_out_valid", 16'(out_valid), 16'd0);
    wait_valid("add_latency", 1);
    chk("add_result", result_q, 16'h7FFF);
    chk("add_flags", zvn(), 16'b100 >> 1 | 16'd0 + 16'b010); // Z=0 V=1 N=0
    drain();
    chk("add_drain_out_valid", 16'(out_valid), 16'd0);
    chk("add_drain_in_ready", 16'(in_ready), 16'd1);

    // Build prior flags Z=1 V=0 N=1, then LLB must leave them untouched
    issue(4'h0, 16'h4000, 16'h4000, 16'h0, 16'h0, 16'h8000, 1'b0);
    wait_valid("add2_latency", 1);
    chk("add2_flags", zvn(), 16'b001);
    drain();
    issue(4'h2, 16'h00F0, 16'h00F0, 16'h0, 16'h0, 16'h0000, 1'b0);
    wait_valid("xor_latency", 1);
    chk("xor_flags", zvn(), 16'b101);
    drain();
    issue(4'hA, 16'hFFFF, 16'h2222, 16'h1234, 16'h00AB, 16'h00AB, 1'b1);
    chk("llb_alu_A", alu_A, 16'h1234);
    chk("llb_alu_B", alu_B, 16'h00AB);
    chk("llb_alu_op", 16'(alu_op), 16'h000A);
    wait_valid("llb_latency", 1);
    chk("llb_result", result_q, 16'h00AB);
    chk("llb_flags", zvn(), 16'b101);
    drain();

    // RED takes the extra cycle and leaves flags alone; XOR to zero then sets only Z
    issue(4'h0, 16'h0003, 16'h0002, 16'h0, 16'h0, 16'h0005, 1'b1);
    wait_valid("add3_latency", 1);
    chk("add3_flags", zvn(), 16'b010);
    drain();
    issue(4'h3, 16'h1111, 16'h2222, 16'h0, 16'h0, 16'h0000, 1'b0);
    chk("red_alu_B", alu_B, 16'h2222);
    wait_valid("red_latency", 2);
    chk("red_result", result_q, 16'h0000);
    chk("red_flags", zvn(), 16'b010);
    drain();
    issue(4'h2, 16'h0F0F, 16'h0F0F, 16'h0, 16'h0, 16'h0000, 1'b0);
    wait_valid("xor2_latency", 1);
    chk("xor2_flags", zvn(), 16'b110);
    drain();

    // Backpressure, then back-to-back SUB accept from HOLD
    issue(4'h0, 16'h0101, 16'h1010, 16'h0, 16'h0, 16'h1111, 1'b0);
    wait_valid("bp_latency", 1);
    held_res = result_q; held_a = alu_A; held_b = alu_B;
    chk("bp_result_first", held_res, 16'h1111);
    alu_result = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_out_valid", 16'(out_valid), 16'd1);
      chk("bp_result", result_q, held_res);
      chk("bp_alu_A", alu_A, held_a);
      chk("bp_alu_B", alu_B, held_b);
      chk("bp_in_ready", 16'(in_ready), 16'd0);
    end
    opcode = 4'h1; rs_data = 16'h0003; rt_data = 16'h0003; alu_result = 16'h0000; alu_ovfl = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 16'(in_ready), 16'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_alu_op", 16'(alu_op), 16'h0001);
    chk("b2b_alu_A", alu_A, 16'h0003);
    chk("b2b_out_valid", 16'(out_valid), 16'd0);
    wait_valid("sub_latency", 1);
    chk("sub_result", result_q, 16'h0000);
    chk("sub_flags", zvn(), 16'b100);
    drain();

    // HLT: stays halted regardless of in_valid until reset
    opcode = 4'hF; in_valid = 1'b1;
    tick();
    opcode = 4'h0;
    for (int i = 0; i < 10; i++) begin
      chk("hlt_halted", 16'(halted), 16'd1);
      chk("hlt_in_ready", 16'(in_ready), 16'd0);
      tick();
    end
    chk("hlt_alu_op", 16'(alu_op), 16'h000F);
    chk("hlt_out_valid", 16'(out_valid), 16'd0);
    chk("hlt_flags", zvn(), 16'b100);
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hrst_halted", 16'(halted), 16'd0);
    chk("hrst_in_ready", 16'(in_ready), 16'd1);
    chk("hrst_alu_op", 16'(alu_op), 16'h0000);
    chk("hrst_alu_A", alu_A, 16'h0000);
    chk("hrst_flags", zvn(), 16'd0);

    // Reset in the middle of RED execution
    issue(4'h0, 16'h4000, 16'h4000, 16'h0, 16'h0, 16'h8000, 1'b1);
    wait_valid("add4_latency", 1);
    chk("add4_flags", zvn(), 16'b011);
    drain();
    issue(4'h3, 16'h0001, 16'h0002, 16'h0, 16'h0, 16'h7777, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("xrst_flags", zvn(), 16'd0);
    chk("xrst_in_ready", 16'(in_ready), 16'd1);
    chk("xrst_result", result_q, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      chk("xrst_out_valid", 16'(out_valid), 16'd0);
      tick();
    end
    issue(4'h0, 16'h0000, 16'h0001, 16'h0, 16'h0, 16'h0001, 1'b0);
    chk("post_alu_B", alu_B, 16'h0001);
    wait_valid("post_latency", 1);
    chk("post_result", result_q, 16'h0001);
    chk("post_flags", zvn(), 16'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
